// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the LSU, one outstanding transaction.
// Optional IF anti-starvation logic is enabled by defining MEM_ARB_FAIR_EN.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_adr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            lsu_req_i,
  input  logic [XLEN-1:0] lsu_adr_i,
  input  logic            lsu_we_i,
  input  logic [2:0]      lsu_size_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  output logic            lsu_gnt_o,
  output logic            lsu_rvalid_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  input  logic            flush_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_adr_o,
  output logic            mem_we_o,
  output logic [2:0]      mem_size_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            busy_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   drop_q,  drop_d;

  logic   arb_open_s;
  logic   if_req_eff_s;
  logic   if_prio_s;
  logic   sel_if_s;
  logic   sel_lsu_s;
  logic   grant_s;
  logic   resp_s;

`ifdef MEM_ARB_FAIR_EN
  localparam int unsigned CNT_W = (STARVE_MAX < 32'd1) ? 32'd1 : $clog2(STARVE_MAX + 32'd1);
  logic [CNT_W-1:0] starve_q, starve_d;

  // IF gets priority once it has been held off STARVE_MAX consecutive cycles
  always_comb begin
    if_prio_s = (starve_q == CNT_W'(STARVE_MAX));
  end

  // Starvation counter: counts blocked IF request cycles, saturating
  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || (grant_s && sel_if_s)) begin
      starve_d = {CNT_W{1'b0}};
    end else if (starve_q != CNT_W'(STARVE_MAX)) begin
      starve_d = starve_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_q <= {CNT_W{1'b0}};
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic starve_max_unused_s;

  // Fixed LSU priority build: IF never overrides the LSU
  always_comb begin
    if_prio_s           = 1'b0;
    starve_max_unused_s = (STARVE_MAX == 32'd0);
  end
`endif

  // Arbitration window and requester selection; a flush hides the fetch request
  always_comb begin
    arb_open_s   = 1'b0;
    if_req_eff_s = if_req_i & ~flush_i;
    sel_if_s     = 1'b0;
    sel_lsu_s    = 1'b0;
    if (!reset_n) begin
      arb_open_s = 1'b0;
    end else if (state_q == ST_IDLE) begin
      arb_open_s = 1'b1;
    end else begin
      arb_open_s = mem_rvalid_i;
    end
    if (arb_open_s) begin
      if (if_req_eff_s && (if_prio_s || !lsu_req_i)) begin
        sel_if_s = 1'b1;
      end else if (lsu_req_i) begin
        sel_lsu_s = 1'b1;
      end else begin
        sel_if_s  = 1'b0;
        sel_lsu_s = 1'b0;
      end
    end else begin
      sel_if_s  = 1'b0;
      sel_lsu_s = 1'b0;
    end
  end

  // Memory request mux and same-cycle grant / response routing
  always_comb begin
    mem_req_o   = sel_if_s | sel_lsu_s;
    mem_adr_o   = {XLEN{1'b0}};
    mem_we_o    = 1'b0;
    mem_size_o  = 3'b000;
    mem_wdata_o = {XLEN{1'b0}};
    if (sel_lsu_s) begin
      mem_adr_o   = lsu_adr_i;
      mem_we_o    = lsu_we_i;
      mem_size_o  = lsu_size_i;
      mem_wdata_o = lsu_wdata_i;
    end else if (sel_if_s) begin
      mem_adr_o   = if_adr_i;
      mem_size_o  = 3'b010;
    end else begin
      mem_adr_o   = {XLEN{1'b0}};
    end
    grant_s      = mem_req_o & mem_gnt_i;
    if_gnt_o     = grant_s & sel_if_s;
    lsu_gnt_o    = grant_s & sel_lsu_s;
    resp_s       = reset_n & (state_q == ST_RESP) & mem_rvalid_i;
    if_rvalid_o  = resp_s & (owner_q == OWN_IF) & ~drop_q & ~flush_i;
    lsu_rvalid_o = resp_s & (owner_q == OWN_LSU);
    if_rdata_o   = if_rvalid_o  ? mem_rdata_i : {XLEN{1'b0}};
    lsu_rdata_o  = lsu_rvalid_o ? mem_rdata_i : {XLEN{1'b0}};
    busy_o       = reset_n & (state_q == ST_RESP);
  end

  // Next-state, owner and drop-flag logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    drop_d  = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_s) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (mem_rvalid_i) begin
          state_d = grant_s ? ST_RESP : ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (grant_s) begin
      owner_d = sel_lsu_s ? OWN_LSU : OWN_IF;
      drop_d  = sel_if_s & flush_i;
    end else if (resp_s) begin
      owner_d = owner_q;
      drop_d  = 1'b0;
    end else if ((state_q == ST_RESP) && (owner_q == OWN_IF) && flush_i) begin
      owner_d = owner_q;
      drop_d  = 1'b1;
    end else begin
      owner_d = owner_q;
      drop_d  = drop_q;
    end
  end

  // State, owner and drop-flag registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IF;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
    end
  end

endmodule
